// File: rtl/box_pyramid_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : box_pkg
//  Description : Shared types and helpers for the box-counting pyramid
//                reducer: reduction-mode encoding, controller state
//                encoding and the {level, x, y} box-memory address packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package box_pkg;

    // Reduction mode, latched at start. 2'b11 is reserved and reduces as sum.
    typedef enum logic [1:0] {
        MODE_SUM  = 2'b00,
        MODE_MAX  = 2'b01,
        MODE_OR   = 2'b10,
        MODE_RSVD = 2'b11
    } box_mode_e;

    // Controller state encoding. The controller keeps its state in a plain
    // logic vector and compares against these constants; the enum gives the
    // same encoding a readable name in waveforms.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    typedef enum logic [1:0] {
        BOX_ST_IDLE = ST_IDLE,
        BOX_ST_RD   = ST_RD,
        BOX_ST_WAIT = ST_WAIT,
        BOX_ST_WR   = ST_WR
    } box_state_e;

    // Packs {level, x, y} with x and y each occupying grid_log2 bits,
    // right-aligned. The caller truncates the result to its address width.
    function automatic logic [31:0] box_pack_addr(
        input int unsigned grid_log2,
        input logic [31:0] level,
        input logic [31:0] x,
        input logic [31:0] y
    );
        return (level << (2 * grid_log2)) | (x << grid_log2) | y;
    endfunction

endpackage : box_pkg
`default_nettype wire

// File: rtl/box_pyramid_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : box_pyramid_gen_if
//  Description : Control and box-memory bundle of the pyramid reducer.
//                slave  : the reducer (takes start/mode/rd_data, drives the
//                         status and memory strobes)
//                master : the surrounding system (loader + memory model)
//  Signals     : start, mode, busy, done, level_done, cur_level,
//                rd_en, rd_addr, rd_data, wr_en, wr_addr, wr_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface box_pyramid_gen_if #(
    parameter int DW        = 8,
    parameter int GRID_LOG2 = 3,
    parameter int LW        = $clog2(GRID_LOG2 + 1)
);
    localparam int AW = LW + 2 * GRID_LOG2;

    logic           start;
    logic [1:0]     mode;
    logic           busy;
    logic           done;
    logic           level_done;
    logic [LW-1:0]  cur_level;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;

    modport master (
        output start, mode, rd_data,
        input  busy, done, level_done, cur_level,
               rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, mode, rd_data,
        output busy, done, level_done, cur_level,
               rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

endinterface : box_pyramid_gen_if
`default_nettype wire

// File: rtl/box_pyramid_gen_reduce_alu.sv
`default_nettype none
// ============================================================================
//  Module      : box_reduce_alu
//  Description : Combinational fold of one box-memory datum into the running
//                accumulator, plus the final accumulator-to-cell conversion.
//                Sum uses a DW+2 bit accumulator (four DW-bit terms never
//                overflow it); max is an unsigned compare; OR keeps a 0/1
//                occupancy flag.
//  Macro       : BOX_SAT_EN - sum results above 2^DW-1 saturate; otherwise
//                the low DW bits are returned (wrap).
//  Ports       : mode_i   reduction mode
//                first_i  datum is the first of its box (initialises acc)
//                acc_i    current accumulator
//                data_i   incoming datum
//                acc_o    folded accumulator
//                result_o cell value to write for acc_i
//  Revision    : 1.0 - initial release
// ============================================================================
module box_reduce_alu
    import box_pkg::*;
#(
    parameter int DW = 8
) (
    input  wire logic [1:0]    mode_i,
    input  wire logic          first_i,
    input  wire logic [DW+1:0] acc_i,
    input  wire logic [DW-1:0] data_i,
    output logic      [DW+1:0] acc_o,
    output logic      [DW-1:0] result_o
);

    logic [DW+1:0] w_data_ext;
    logic [DW+1:0] w_occ;

    always_comb begin
        w_data_ext = {2'b00, data_i};
        w_occ      = {{(DW+1){1'b0}}, |data_i};
        acc_o      = acc_i;
        case (mode_i)
            MODE_MAX: acc_o = (first_i || (w_data_ext > acc_i)) ? w_data_ext : acc_i;
            MODE_OR:  acc_o = first_i ? w_occ : (acc_i | w_occ);
            default:  acc_o = first_i ? w_data_ext : (acc_i + w_data_ext);
        endcase
    end

    always_comb begin
        result_o = acc_i[DW-1:0];
        if ((mode_i != MODE_MAX) && (mode_i != MODE_OR)) begin
`ifdef BOX_SAT_EN
            result_o = (acc_i[DW+1:DW] != 2'b00) ? {DW{1'b1}} : acc_i[DW-1:0];
`else
            result_o = acc_i[DW-1:0];
`endif
        end
    end

endmodule : box_reduce_alu
`default_nettype wire

// File: rtl/box_pyramid_gen.sv
`default_nettype none
// ============================================================================
//  Module      : box_pyramid_gen
//  Description : Multi-level box-counting reducer. Reduces each 2x2 box of
//                level L into one cell of level L+1, level by level, until a
//                1x1 grid remains. Every box takes six cycles: four reads,
//                one wait for the last datum, one write.
//  Macro       : BOX_SAT_EN (in box_reduce_alu) - saturating sum mode.
//  Ports       : CLK  clock
//                RST  asynchronous active-high reset
//                bus  box_pyramid_gen_if.slave: start/mode in, busy/done/
//                     level_done/cur_level out, box-memory read and write
//                     ports ({level, x, y} addresses)
//  Revision    : 1.0 - initial release
// ============================================================================
module box_pyramid_gen
    import box_pkg::*;
#(
    parameter int DW        = 8,
    parameter int GRID_LOG2 = 3,
    parameter int LW        = $clog2(GRID_LOG2 + 1)
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    box_pyramid_gen_if.slave    bus
);

    localparam int GW = GRID_LOG2;
    localparam int AW = LW + 2 * GRID_LOG2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     state_q, state_d;
    logic [1:0]     k_q,     k_d;      // read index within the box
    logic [LW-1:0]  lvl_q,   lvl_d;    // source level
    logic [GW-1:0]  i_q,     i_d;      // output x (inner loop)
    logic [GW-1:0]  j_q,     j_d;      // output y (outer loop)
    logic [1:0]     mode_q,  mode_d;
    logic [DW+1:0]  acc_q,   acc_d;
    logic           fold_q,  fold_d;   // rd_data this cycle belongs to a read
    logic           first_q, first_d;  // ...and it is read 0 of the box

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [31:0]    w_shift;
    logic [GW-1:0]  w_half_m1;         // S/2 - 1 at the current level
    logic           w_last_i;
    logic           w_last_j;
    logic           w_last_box;
    logic           w_last_lvl;
    logic [GW-1:0]  w_src_x;
    logic [GW-1:0]  w_src_y;
    logic [LW-1:0]  w_dst_lvl;
    logic [AW-1:0]  w_rd_addr;
    logic [AW-1:0]  w_wr_addr;
    logic [DW+1:0]  w_acc_next;
    logic [DW-1:0]  w_result;
    logic           w_rd;
    logic           w_wr;

    always_comb begin
        // S/2 = 2^(GRID_LOG2-1-L); lvl_q never exceeds GRID_LOG2-1.
        w_shift    = 32'(GRID_LOG2 - 1) - {{(32-LW){1'b0}}, lvl_q};
        w_half_m1  = GW'((32'd1 << w_shift) - 32'd1);
        w_last_i   = (i_q == w_half_m1);
        w_last_j   = (j_q == w_half_m1);
        w_last_box = w_last_i && w_last_j;
        w_last_lvl = (lvl_q == LW'(GRID_LOG2 - 1));
        // Read order (0,0),(1,0),(0,1),(1,1): kx = k[0], ky = k[1].
        w_src_x    = GW'({i_q, k_q[0]});
        w_src_y    = GW'({j_q, k_q[1]});
        w_dst_lvl  = lvl_q + LW'(1);
        w_rd_addr  = AW'(box_pack_addr(GRID_LOG2, 32'(lvl_q), 32'(w_src_x), 32'(w_src_y)));
        w_wr_addr  = AW'(box_pack_addr(GRID_LOG2, 32'(w_dst_lvl), 32'(i_q), 32'(j_q)));
        w_rd       = (state_q == ST_RD);
        w_wr       = (state_q == ST_WR);
    end

    box_reduce_alu #(
        .DW       (DW)
    ) u_alu (
        .mode_i   (mode_q),
        .first_i  (first_q),
        .acc_i    (acc_q),
        .data_i   (bus.rd_data),
        .acc_o    (w_acc_next),
        .result_o (w_result)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lvl_d   = lvl_q;
        i_d     = i_q;
        j_d     = j_q;
        mode_d  = mode_q;
        acc_d   = fold_q ? w_acc_next : acc_q;
        fold_d  = w_rd;
        first_d = w_rd && (k_q == 2'd0);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RD;
                    k_d     = 2'd0;
                    lvl_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                end
            end
            ST_RD: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_RD;
                k_d     = 2'd0;
                if (w_last_box) begin
                    i_d = '0;
                    j_d = '0;
                    if (w_last_lvl) begin
                        state_d = ST_IDLE;
                        lvl_d   = '0;
                    end else begin
                        lvl_d   = w_dst_lvl;
                    end
                end else if (w_last_i) begin
                    i_d = '0;
                    j_d = j_q + GW'(1);
                end else begin
                    i_d = i_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            lvl_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            fold_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lvl_q   <= lvl_d;
            i_q     <= i_d;
            j_q     <= j_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            fold_q  <= fold_d;
            first_q <= first_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (addresses and data gated so they read zero when idle)
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy       = (state_q != ST_IDLE);
        bus.rd_en      = w_rd;
        bus.rd_addr    = w_rd ? w_rd_addr : '0;
        bus.wr_en      = w_wr;
        bus.wr_addr    = w_wr ? w_wr_addr : '0;
        bus.wr_data    = w_wr ? w_result  : '0;
        bus.level_done = w_wr && w_last_box;
        bus.done       = w_wr && w_last_box && w_last_lvl;
        bus.cur_level  = lvl_q;
    end

endmodule : box_pyramid_gen
`default_nettype wire

// File: tb/tb_box_pyramid_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_box_pyramid_gen
//  Description : Directed self-checking bench for box_pyramid_gen with a
//                256-entry box-memory model (one-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_box_pyramid_gen;
    import box_pkg::*;

    localparam int DW = 8;
    localparam int G  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    box_pyramid_gen_if #(.DW(DW), .GRID_LOG2(G)) bus ();

    box_pyramid_gen #(.DW(DW), .GRID_LOG2(G)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Box memory: address = level*64 + x*8 + y. Levels 1..3 are preset to a
    // sentinel on every load so that missing writes show up.
    logic [7:0] mem [0:255];
    logic [7:0] img [0:63];
    logic       load_go = 1'b0;

    always @(posedge CLK) begin
        if (load_go) begin
            for (int a = 0; a < 256; a++) begin
                mem[a] <= (a < 64) ? img[a[5:0]] : 8'hA5;
            end
        end else begin
            if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
            if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load_img();
        load_go = 1'b1;
        @(negedge CLK);
        load_go = 1'b0;
    endtask

    // Pulses start (mode changes right after to prove it was latched) and
    // waits, bounded, for done. dcyc is the cycle done appeared (-1 = none).
    task automatic run_box(input logic [1:0] m, output int dcyc);
        dcyc = -1;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.mode  = m;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.mode  = 2'b11;
        for (int c = 1; c <= 200 && dcyc < 0; c++) begin
            if (bus.done === 1'b1) dcyc = c;
            else @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        n_total++;
        if ({bus.busy, bus.done, bus.level_done, bus.rd_en, bus.wr_en} !== 5'b0)
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.busy, bus.done, bus.level_done, bus.rd_en, bus.wr_en});
        else n_pass++;
        n_total++;
        if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.cur_level} !== '0)
            $display("FAIL reset_buses: rd_addr=%0d wr_addr=%0d wr_data=%0d cur_level=%0d expected all 0",
                     bus.rd_addr, bus.wr_addr, bus.wr_data, bus.cur_level);
        else n_pass++;
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // Sum of all ones with cycle-accurate strobe checks and an ignored start.
    task automatic test_timing();
        int        nwr     = 0;
        int        ndone   = 0;
        int        done_c  = -1;
        int        ld_pack = 0;
        logic [7:0] exp_a [4];
        logic [7:0] exp_v;
        exp_a[0] = 8'd0; exp_a[1] = 8'd8; exp_a[2] = 8'd1; exp_a[3] = 8'd9;
        for (int a = 0; a < 64; a++) img[a] = 8'd1;
        load_img();
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        @(negedge CLK);
        bus.start = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            if (c >= 1 && c <= 4) begin
                n_total++;
                if (bus.rd_en !== 1'b1 || bus.rd_addr !== exp_a[c-1])
                    $display("FAIL timing_rd c%0d: rd_en=%b rd_addr=%0d expected 1/%0d",
                             c, bus.rd_en, bus.rd_addr, exp_a[c-1]);
                else n_pass++;
            end
            if (c == 5) begin
                n_total++;
                if ({bus.rd_en, bus.wr_en} !== 2'b00)
                    $display("FAIL timing_wait: rd_en/wr_en=%b expected 00", {bus.rd_en, bus.wr_en});
                else n_pass++;
            end
            if (c == 6) begin
                n_total++;
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd64 || bus.wr_data !== 8'd4)
                    $display("FAIL timing_first_wr: wr_en=%b wr_addr=%0d wr_data=%0d expected 1/64/4",
                             bus.wr_en, bus.wr_addr, bus.wr_data);
                else n_pass++;
            end
            if (c == 100 || c == 125) begin
                n_total++;
                if (bus.cur_level !== ((c == 100) ? 2'd1 : 2'd2))
                    $display("FAIL timing_cur_level c%0d: got %0d expected %0d",
                             c, bus.cur_level, (c == 100) ? 1 : 2);
                else n_pass++;
            end
            if (bus.wr_en === 1'b1) nwr++;
            if (bus.level_done === 1'b1) ld_pack = ld_pack * 100 + nwr;
            if (bus.done === 1'b1) begin
                ndone++;
                done_c = c;
            end
            if (c == 50) begin
                bus.start = 1'b1;
                bus.mode  = 2'b01;
            end
            if (c == 51) begin
                bus.start = 1'b0;
                bus.mode  = 2'b00;
            end
            @(negedge CLK);
        end
        n_total++;
        if (nwr !== 21) $display("FAIL timing_wr_count: got %0d expected 21", nwr);
        else n_pass++;
        n_total++;
        if (ld_pack !== 162021)
            $display("FAIL timing_level_done: write indices %0d expected 162021", ld_pack);
        else n_pass++;
        n_total++;
        if (ndone !== 1 || done_c !== 126)
            $display("FAIL timing_done: count=%0d cycle=%0d expected 1/126", ndone, done_c);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL timing_idle_after: busy=%b expected 0", bus.busy);
        else n_pass++;
        for (int l = 1; l <= 3; l++) begin
            for (int x = 0; x < (8 >> l); x++) begin
                for (int y = 0; y < (8 >> l); y++) begin
                    exp_v = (l == 1) ? 8'd4 : (l == 2) ? 8'd16 : 8'd64;
                    n_total++;
                    if (mem[l*64 + x*8 + y] !== exp_v)
                        $display("FAIL sum_ones L%0d(%0d,%0d): got %0d expected %0d",
                                 l, x, y, mem[l*64 + x*8 + y], exp_v);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_sum_sat();
        int         dcyc;
        logic [7:0] exp_v;
        for (int a = 0; a < 64; a++) img[a] = 8'd255;
        load_img();
        run_box(2'b00, dcyc);
        n_total++;
        if (dcyc !== 126) $display("FAIL sum255_done: cycle %0d expected 126", dcyc);
        else n_pass++;
        for (int l = 1; l <= 3; l++) begin
            for (int x = 0; x < (8 >> l); x++) begin
                for (int y = 0; y < (8 >> l); y++) begin
`ifdef BOX_SAT_EN
                    exp_v = 8'd255;
`else
                    exp_v = (l == 1) ? 8'd252 : (l == 2) ? 8'd240 : 8'd192;
`endif
                    n_total++;
                    if (mem[l*64 + x*8 + y] !== exp_v)
                        $display("FAIL sum255 L%0d(%0d,%0d): got %0d expected %0d",
                                 l, x, y, mem[l*64 + x*8 + y], exp_v);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_max();
        int         dcyc;
        logic [7:0] exp_v;
        for (int a = 0; a < 64; a++) img[a] = 8'd0;
        img[5*8 + 2] = 8'd200;
        load_img();
        run_box(2'b01, dcyc);
        n_total++;
        if (dcyc !== 126) $display("FAIL max_done: cycle %0d expected 126", dcyc);
        else n_pass++;
        for (int l = 1; l <= 3; l++) begin
            for (int x = 0; x < (8 >> l); x++) begin
                for (int y = 0; y < (8 >> l); y++) begin
                    exp_v = (x == (5 >> l) && y == (2 >> l)) ? 8'd200 : 8'd0;
                    n_total++;
                    if (mem[l*64 + x*8 + y] !== exp_v)
                        $display("FAIL max L%0d(%0d,%0d): got %0d expected %0d",
                                 l, x, y, mem[l*64 + x*8 + y], exp_v);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_or();
        int         dcyc;
        logic [7:0] exp_v;
        for (int a = 0; a < 64; a++) img[a] = 8'd0;
        img[0*8 + 7] = 8'd7;
        load_img();
        run_box(2'b10, dcyc);
        n_total++;
        if (dcyc !== 126) $display("FAIL or_done: cycle %0d expected 126", dcyc);
        else n_pass++;
        for (int l = 1; l <= 3; l++) begin
            for (int x = 0; x < (8 >> l); x++) begin
                for (int y = 0; y < (8 >> l); y++) begin
                    exp_v = (x == 0 && y == (7 >> l)) ? 8'd1 : 8'd0;
                    n_total++;
                    if (mem[l*64 + x*8 + y] !== exp_v)
                        $display("FAIL or L%0d(%0d,%0d): got %0d expected %0d",
                                 l, x, y, mem[l*64 + x*8 + y], exp_v);
                    else n_pass++;
                end
            end
        end
    endtask

    // Reset at cycle 40 of a run, then a full replay with cell = x + y.
    task automatic test_reset_mid();
        int         dcyc;
        logic [7:0] exp_v;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                img[x*8 + y] = 8'(x + y);
        load_img();
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        @(negedge CLK);
        bus.start = 1'b0;
        for (int c = 1; c < 40; c++) @(negedge CLK);
        n_total++;
        if ({bus.busy, bus.rd_en} !== 2'b11)
            $display("FAIL midrst_pre: busy/rd_en=%b expected 11", {bus.busy, bus.rd_en});
        else n_pass++;
        RST = 1'b1;
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.level_done, bus.rd_en, bus.wr_en,
             bus.rd_addr, bus.wr_addr, bus.wr_data, bus.cur_level} !== '0)
            $display("FAIL midrst_outputs: busy=%b rd_en=%b rd_addr=%0d cur_level=%0d expected all 0",
                     bus.busy, bus.rd_en, bus.rd_addr, bus.cur_level);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL midrst_idle: busy=%b expected 0", bus.busy);
        else n_pass++;
        load_img();
        run_box(2'b00, dcyc);
        n_total++;
        if (dcyc !== 126) $display("FAIL replay_done: cycle %0d expected 126", dcyc);
        else n_pass++;
        for (int l = 1; l <= 3; l++) begin
            for (int x = 0; x < (8 >> l); x++) begin
                for (int y = 0; y < (8 >> l); y++) begin
                    if (l == 1)      exp_v = 8'(8*x + 8*y + 4);
                    else if (l == 2) exp_v = 8'(64*x + 64*y + 48);
                    else begin
`ifdef BOX_SAT_EN
                        exp_v = 8'd255;
`else
                        exp_v = 8'd192;
`endif
                    end
                    n_total++;
                    if (mem[l*64 + x*8 + y] !== exp_v)
                        $display("FAIL replay L%0d(%0d,%0d): got %0d expected %0d",
                                 l, x, y, mem[l*64 + x*8 + y], exp_v);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        for (int a = 0; a < 64; a++) img[a] = 8'd0;
        test_reset();
        test_timing();
        test_sum_sat();
        test_max();
        test_or();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_box_pyramid_gen
`default_nettype wire

// File: doc/box_pyramid_gen.md
Name: box_pyramid_gen

Overview:
Multi-level box-counting reducer for the multifractal-analysis datapath. Starting from a 2^GRID_LOG2 x 2^GRID_LOG2 grid at level 0 of a shared box memory, it repeatedly reduces each 2x2 box into one cell of the next level until a 1x1 grid remains. Sum, max and occupancy (OR) reduction modes are supported, selected per run. It sits between the image loader and the box-count statistics unit, and owns the box-memory ports during a run.

Parameters:
DW, 8, data width of grid cells (input and output)
GRID_LOG2, 3, log2 of level-0 grid side (grid is 8x8 by default)
LW, $clog2(GRID_LOG2+1), level-field width in addresses (derived; do not override)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; starts a run when idle
mode  in  2  00 sum, 01 max, 10 OR/occupancy, 11 reserved (treated as sum); latched at start
busy  out  1  high from the cycle after an accepted start through the done cycle
done  out  1  one-cycle pulse coincident with the final write
level_done  out  1  one-cycle pulse coincident with the last write of each level
cur_level  out  LW  source level being reduced
rd_en  out  1  box-memory read strobe
rd_addr  out  LW+2*GRID_LOG2  {level, x, y}; x and y are right-aligned and zero-padded
rd_data  in  DW  read data, valid the cycle after rd_en
wr_en  out  1  box-memory write strobe
wr_addr  out  LW+2*GRID_LOG2  {level, x, y}, same packing
wr_data  out  DW  reduced value

Behaviour:
- Reset values: busy=0, done=0, level_done=0, rd_en=0, wr_en=0, all addresses 0, wr_data 0, cur_level 0. The FSM returns to IDLE and the accumulator clears.
- FSM states: IDLE -> RD (4 cycles, k=0..3) -> WAIT (1 cycle) -> WR (1 cycle) -> RD for the next box, or the next level, or IDLE after the last box.
- IDLE: on start, latch mode, set L=0 and output coordinates i=j=0, and go to RD. While busy, start is ignored.
- RD cycle k issues rd_en with source address {L, 2i+kx, 2j+ky}. Read order (kx,ky) is (0,0), (1,0), (0,1), (1,1).
- rd_data for read k is folded into the accumulator at the end of cycle k+1. Data 0 initialises the accumulator. The 4th datum is folded at the end of WAIT.
- WR: wr_en=1, wr_addr={L+1, i, j}, wr_data = accumulator. Each box takes exactly 6 cycles, with no overlap between boxes.
- Output scan: i is the inner loop and j the outer loop, each running 0..S/2-1, where S = 2^(GRID_LOG2-L).
- After the last box of level L: pulse level_done, then increment L. When L+1 equals GRID_LOG2, pulse done together with level_done and return to IDLE.
- Run length: 6 x sum over levels of (S/2)^2 cycles. The default is 6 x 21 = 126 write-producing cycles. The first rd_en appears 1 cycle after start; done appears in cycle 126 after the start cycle.
- Arithmetic:
  - Sum mode: DW+2-bit internal accumulator.
  - Max mode: unsigned compare.
  - OR mode: the result is 1 if any input is nonzero, else 0, zero-extended to DW.
- Reset mid-run: all activity aborts immediately. Partial results already written are left in memory. The next start begins at level 0.
- Levels above GRID_LOG2 are never addressed.

Optional Feature:
BOX_SAT_EN
- Defined: in sum mode, a result above 2^DW-1 saturates to 2^DW-1.
- Undefined: the sum wraps, and wr_data is the low DW bits.
- Max and OR modes are unaffected either way.

Decomposition:
- Package box_pkg holds:
  - the mode enum (MODE_SUM, MODE_MAX, MODE_OR)
  - the FSM state enum
  - a function that packs {level, x, y} into an address for a given GRID_LOG2
- One sub-module, box_reduce_alu: a combinational fold of the accumulator with rd_data per mode, plus final saturate/truncate. The controller instantiates it once.

Test Plan:
- Sum, all-ones 8x8 -> level 1 all 4, level 2 all 16, level 3 (0,0)=64; 21 wr_en pulses; level_done at writes 16, 20, 21; done at write 21.
- Sum, all 255 -> level 1 = 255 with BOX_SAT_EN and 252 without; check both builds.
- Max, single 200 at (5,2), rest 0 -> level 1 (2,1)=200, level 2 (1,0)=200, level 3=200, all others 0.
- OR, single 7 at (0,7) -> level 1 (0,3)=1, level 2 (0,1)=1, level 3=1, all others 0.
- Timing: start at cycle 0 -> rd_en cycles 1-4 at addresses {0,0,0}, {0,1,0}, {0,0,1}, {0,1,1}; first wr_en cycle 6 at {1,0,0}; done cycle 126; a start pulse at cycle 50 is ignored.
- Assert RST at cycle 40 -> all outputs 0 in the same cycle. A new start then replays from level 0 with correct results.
